// File: rtl/cmp_pkg.sv
// Shared encodings for the bit-serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // RES_NONE is only held between reset and the first completed compare.
  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_GT   = 2'd1,
    RES_EQ   = 2'd2,
    RES_LT   = 2'd3
  } res_e;

  function automatic res_e res_from_bit(input logic a_wins);
    return a_wins ? RES_GT : RES_LT;
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// One-bit compare cell: flags a difference and whether A is the larger operand at this bit.
module cmp_bit_cell (
  input  logic abit,
  input  logic bbit,
  input  logic msb_flag,
  input  logic signed_mode,
  output logic differ,
  output logic a_wins
);

  always_comb begin
    differ = abit ^ bbit;
    // A set sign bit makes A the smaller operand in two's complement.
    a_wins = differ & ((signed_mode & msb_flag) ? ~abit : abit);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with optional early exit and signed mode.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1,
  parameter bit          SIGNED     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             x,
  output logic             y,
  output logic             z
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IdxW-1:0]  r_idx;
  logic             r_found;
  logic             r_first_gt;
  res_e             r_res;

  logic             w_abit;
  logic             w_bbit;
  logic             w_msb;
  logic             w_last;
  logic             w_differ;
  logic             w_a_wins;
  res_e             w_res_scan;

  assign w_abit = r_a[r_idx];
  assign w_bbit = r_b[r_idx];
  assign w_msb  = (r_idx == IdxMsb);
  assign w_last = (r_idx == '0);

  cmp_bit_cell u_bit_cell (
    .abit        (w_abit),
    .bbit        (w_bbit),
    .msb_flag    (w_msb),
    .signed_mode (SIGNED),
    .differ      (w_differ),
    .a_wins      (w_a_wins)
  );

  // The first recorded difference always wins over later bits.
  always_comb begin
    w_res_scan = RES_EQ;
    if (r_found) begin
      w_res_scan = res_from_bit(r_first_gt);
    end else if (w_differ) begin
      w_res_scan = res_from_bit(w_a_wins);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_next = ST_SCAN;
      ST_SCAN: if ((EARLY_EXIT && w_differ) || w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      ST_SCAN: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
    x = (r_res == RES_GT);
    y = (r_res == RES_EQ);
    z = (r_res == RES_LT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_idx      <= '0;
      r_found    <= 1'b0;
      r_first_gt <= 1'b0;
      r_res      <= RES_NONE;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_a        <= a;
        r_b        <= b;
        r_idx      <= IdxMsb;
        r_found    <= 1'b0;
        r_first_gt <= 1'b0;
      end
      if (r_state == ST_SCAN) begin
        if (!w_last) r_idx <= r_idx - IdxW'(1);
        if (w_differ && !r_found) begin
          r_found    <= 1'b1;
          r_first_gt <= w_a_wins;
        end
        if (w_state_next == ST_DONE) r_res <= w_res_scan;
      end
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench: three comparator configurations share stimulus; a monitor checks each one.
module tb_seq_magnitude_comparator;

  localparam int W = 8;
  localparam int N = 3;
  localparam bit EE [N] = '{1'b1, 1'b0, 1'b1};
  localparam bit SG [N] = '{1'b0, 1'b0, 1'b1};

  typedef struct packed {
    logic [2:0] xyz;
    int         start_cyc;
    int         lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [N-1:0]   busy_w;
  logic [N-1:0]   done_w;
  logic [N-1:0]   x_w;
  logic [N-1:0]   y_w;
  logic [N-1:0]   z_w;

  exp_t           sb [N][$];
  logic [2:0]     last_xyz [N];
  int             cyc = 0;
  int             total = 0;
  int             bad = 0;
  bit             skip = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1), .SIGNED(1'b0)) u_dut_u_ee (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy_w[0]), .done(done_w[0]), .x(x_w[0]), .y(y_w[0]), .z(z_w[0])
  );

  seq_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0), .SIGNED(1'b0)) u_dut_u_full (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy_w[1]), .done(done_w[1]), .x(x_w[1]), .y(y_w[1]), .z(z_w[1])
  );

  seq_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1), .SIGNED(1'b1)) u_dut_s_ee (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy_w[2]), .done(done_w[2]), .x(x_w[2]), .y(y_w[2]), .z(z_w[2])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d @cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  // Reference: compare as integers, latency from the highest differing bit.
  function automatic exp_t model(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input int c);
    exp_t e;
    int   ai;
    int   bi;
    int   hi;
    if (SG[k]) begin
      ai = int'($signed(av));
      bi = int'($signed(bv));
    end else begin
      ai = int'(av);
      bi = int'(bv);
    end
    e.xyz = (ai > bi) ? 3'b100 : ((ai == bi) ? 3'b010 : 3'b001);
    hi = -1;
    for (int i = 0; i < W; i++) if (av[i] != bv[i]) hi = i;
    e.lat = (hi < 0 || !EE[k]) ? W + 1 : W - hi + 1;
    e.start_cyc = c;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] act;
    logic       exp_busy;
    if (!skip) begin
      for (int k = 0; k < N; k++) begin
        act      = {x_w[k], y_w[k], z_w[k]};
        exp_busy = (sb[k].size() > 0) && (cyc > sb[k][0].start_cyc);
        chk("busy", k, 32'(busy_w[k]), 32'(exp_busy));
        if (sb[k].size() == 0) begin
          chk("done_idle", k, 32'(done_w[k]), 32'(0));
          chk("xyz_hold", k, 32'(act), 32'(last_xyz[k]));
        end else if (done_w[k]) begin
          e = sb[k].pop_front();
          chk("latency", k, 32'(cyc - e.start_cyc), 32'(e.lat));
          chk("xyz_result", k, 32'(act), 32'(e.xyz));
          last_xyz[k] = e.xyz;
        end else begin
          chk("xyz_hold", k, 32'(act), 32'(last_xyz[k]));
        end
      end
    end
  end

  task automatic finish_test();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    for (int k = 0; k < N; k++) sb[k].push_back(model(k, av, bv, cyc));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb[0].size() > 0 || sb[1].size() > 0 || sb[2].size() > 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 60) begin
        total++;
        bad++;
        $display("FAIL timeout waiting for done @cyc %0d: got no done expected done", cyc);
        finish_test();
      end
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    for (int k = 0; k < N; k++) last_xyz[k] = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    skip = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Directed cases; back-to-back since each issue follows the idle cycle directly.
    issue(8'h80, 8'h7F); wait_idle();
    issue(8'h5A, 8'h5A); wait_idle();
    issue(8'h01, 8'h02); wait_idle();
    issue(8'h80, 8'h01); wait_idle();
    issue(8'hFF, 8'hFE); wait_idle();
    issue(8'h00, 8'hFF); wait_idle();
    issue(8'h7F, 8'h80); wait_idle();

    // Start while busy must be ignored.
    issue(8'h12, 8'h34);
    @(posedge clk);
    #1;
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Reset in the third scan cycle aborts without a done pulse.
    issue(8'h3C, 8'h3C);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    skip = 1'b1;
    rst  = 1'b1;
    for (int k = 0; k < N; k++) begin
      sb[k].delete();
      last_xyz[k] = 3'b000;
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    skip = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    issue(8'hC3, 8'h3C); wait_idle();

    for (int t = 0; t < 120; t++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      issue(ra, rb);
      wait_idle();
    end

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    finish_test();
  end

endmodule
